// File: rtl/dcache_miss_controller.sv
// D-cache miss sequencer: pipeline hit/stall, memory request, line refill.
// Optional DCACHE_PERF_CNT_EN adds miss_count and stall_cycles outputs.
module dcache_miss_controller #(
    parameter int ADDR_W       = 32,
    parameter int LINE_WORDS   = 4,
    parameter int MISS_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              tag_match,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              refill_we,
    output logic              pipe_hit,
    output logic              stall,
    output logic              timeout_err
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       miss_count,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int WI_W  = $clog2(LINE_WORDS);
    localparam int OFF_W = WI_W + 2;
    localparam int CNT_W = $clog2(MISS_TIMEOUT);

    localparam logic [WI_W-1:0]  LAST_W = WI_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(MISS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REFILL,
        RESUME
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                terr_q, terr_d;
    logic [WI_W-1:0]     widx_q, widx_d;
    logic [CNT_W-1:0]    tcnt_q, tcnt_d;

    logic                access;
    logic                miss;
    logic                is_idle;
    logic                is_resume;
    logic [ADDR_W-1:0]   req_base;
    logic [ADDR_W-1:0]   line_base;
    logic [WI_W-1:0]     widx_inc;
    logic                unused_addr_lsb;

    assign access    = mem_rd | mem_wr;
    assign miss      = access & ~tag_match;
    assign is_idle   = (state_q == IDLE);
    assign is_resume = (state_q == RESUME);

    assign req_base  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign line_base = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign widx_inc  = widx_q + WI_W'(1);

    assign unused_addr_lsb = ^addr[OFF_W-1:0];

    // Combinational outputs forced low while reset is held.
    assign pipe_hit = rst_n & ((is_idle & ~miss) | is_resume);
    assign stall    = rst_n & (~is_idle | miss);

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign refill_we   = we_q;
    assign timeout_err = terr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            terr_q  <= 1'b0;
            widx_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            terr_q  <= terr_d;
            widx_q  <= widx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = we_q;
        terr_d  = terr_q;
        widx_d  = widx_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = REQ;
                    addr_d  = req_base;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = REFILL;
                    req_d   = 1'b0;
                    we_d    = 1'b1;
                    widx_d  = '0;
                    addr_d  = line_base;
                end else if (tcnt_q == T_MAX) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            REFILL: begin
                if (widx_q == LAST_W) begin
                    state_d = RESUME;
                    we_d    = 1'b0;
                    widx_d  = '0;
                    addr_d  = line_base;
                end else begin
                    // Only the word offset advances; line base stays fixed.
                    widx_d = widx_inc;
                    addr_d = {addr_q[ADDR_W-1:OFF_W], widx_inc, 2'b00};
                end
            end
            RESUME: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (is_idle && miss) begin
                miss_count <= miss_count + 32'd1;
            end
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Scoreboard bench for dcache_miss_controller: random hits, misses, timeouts.
// Expected events are queued by the driver and popped by negedge monitors.
module tb_dcache_miss_controller;

    localparam int AW = 32;
    localparam int LW = 4;
    localparam int MT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_rd;
    logic          mem_wr;
    logic          tag_match;
    logic [AW-1:0] addr;
    logic          mem_ack;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          refill_we;
    logic          pipe_hit;
    logic          stall;
    logic          timeout_err;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]   miss_count;
    logic [31:0]   stall_cycles;
`endif

    dcache_miss_controller #(
        .ADDR_W(AW),
        .LINE_WORDS(LW),
        .MISS_TIMEOUT(MT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .tag_match(tag_match),
        .addr(addr),
        .mem_ack(mem_ack),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .refill_we(refill_we),
        .pipe_hit(pipe_hit),
        .stall(stall),
        .timeout_err(timeout_err)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .miss_count(miss_count),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          len;
    } req_t;

    req_t        req_q[$];
    logic [31:0] refill_q[$];
    logic [2:0]  hit_q[$];
    int          stall_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    int te_model    = 0;
    int miss_model  = 0;
    int stall_model = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request monitor: address at rising edge, pulse length at falling edge.
    initial begin
        bit   on;
        int   cnt;
        req_t cur;
        on = 0;
        cnt = 0;
        cur = '{a: 0, len: -1};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_req) begin
                    if (!on) begin
                        on = 1;
                        cnt = 0;
                        if (req_q.size() == 0) begin
                            check("req_unexpected", 32'd1, 32'd0);
                            cur = '{a: 0, len: -1};
                        end else begin
                            cur = req_q.pop_front();
                            check("req_addr", mem_addr, cur.a);
                        end
                    end
                    cnt++;
                end else if (on) begin
                    on = 0;
                    check("req_len", 32'(cnt), 32'(cur.len));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && refill_we) begin
                if (refill_q.size() == 0)
                    check("refill_unexpected", 32'd1, 32'd0);
                else
                    check("refill_addr", mem_addr, refill_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && pipe_hit && (stall || mem_rd || mem_wr)) begin
                if (hit_q.size() == 0)
                    check("hit_unexpected", 32'd1, 32'd0);
                else
                    check("hit_flags", {29'd0, stall, mem_req, refill_we},
                          {29'd0, hit_q.pop_front()});
            end
        end
    end

    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall) begin
                    run++;
                end else if (run > 0) begin
                    if (stall_q.size() == 0)
                        check("stall_unexpected", 32'(run), 32'd0);
                    else
                        check("stall_len", 32'(run), 32'(stall_q.pop_front()));
                    run = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        addr      = $urandom;
        mem_rd    = 1'($urandom);
        mem_wr    = 1'($urandom);
        tag_match = 1'($urandom);
    endtask

    // kind 0 = hit, otherwise miss; ack on k-th REQ cycle, k>MT = never.
    task automatic txn(input int kind, input logic [31:0] a,
                       input int sel, input int k);
        logic [31:0] base;
        base = a & ~32'hF;
        addr = a;
        mem_rd = sel[0];
        mem_wr = sel[1];
        mem_ack = 1'($urandom);
        if (kind == 0) begin
            tag_match = 1'b1;
            hit_q.push_back(3'b000);
            step();
        end else begin
            tag_match = 1'b0;
            miss_model++;
            if (k <= MT) begin
                req_q.push_back('{a: base, len: k});
                for (int w = 0; w < LW; w++)
                    refill_q.push_back(base + 32'(4 * w));
                hit_q.push_back(3'b100);
                stall_q.push_back(1 + k + LW + 1);
                stall_model += 1 + k + LW + 1;
            end else begin
                req_q.push_back('{a: base, len: MT});
                stall_q.push_back(1 + MT);
                stall_model += 1 + MT;
                te_model = 1;
            end
            step();
            if (k <= MT) begin
                for (int j = 1; j <= k; j++) begin
                    scramble();
                    mem_ack = (j == k);
                    step();
                end
                for (int j = 0; j < LW + 1; j++) begin
                    scramble();
                    mem_ack = 1'($urandom);
                    step();
                end
            end else begin
                for (int j = 1; j <= MT; j++) begin
                    scramble();
                    mem_ack = 1'b0;
                    step();
                end
            end
        end
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        tag_match = 1'($urandom);
        addr = $urandom;
        mem_ack = 1'($urandom);
        check("timeout_err", {31'd0, timeout_err}, 32'(te_model));
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rd = 1'b1;
        mem_wr = 1'b0;
        tag_match = 1'b0;
        addr = 32'h0000_1234;
        mem_ack = 1'b1;
        @(negedge clk);
        check("rst_pipe_hit", {31'd0, pipe_hit}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_refill_we", {31'd0, refill_we}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        step();
        rst_n = 1'b1;
        mem_rd = 1'b0;
        mem_ack = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 3; i++)
            txn(0, $urandom, 1, 0);
        txn(1, 32'h0000_1234, 1, 3);
        txn(1, 32'h0000_ABC8, 3, 1);
        txn(1, 32'h0000_4444, 2, MT + 1);
        for (int i = 0; i < 60; i++)
            txn($urandom_range(0, 2), $urandom, $urandom_range(1, 3),
                $urandom_range(1, MT + 2));

        step();
        step();
        check("req_q_empty", 32'(req_q.size()), 32'd0);
        check("refill_q_empty", 32'(refill_q.size()), 32'd0);
        check("hit_q_empty", 32'(hit_q.size()), 32'd0);
        check("stall_q_empty", 32'(stall_q.size()), 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("miss_count", miss_count, 32'(miss_model));
        check("stall_cycles", stall_cycles, 32'(stall_model));
`endif
        mon_en = 1'b0;

        addr = 32'h0000_5678;
        mem_rd = 1'b1;
        tag_match = 1'b0;
        mem_ack = 1'b0;
        step();
        mem_rd = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        check("mid_refill_we", {31'd0, refill_we}, 32'd1);
        check("mid_refill_addr", mem_addr, 32'h0000_5674);
        rst_n = 1'b0;
        #1;
        check("arst_refill_we", {31'd0, refill_we}, 32'd0);
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mem_rd = 1'b1;
        tag_match = 1'b1;
        @(negedge clk);
        check("post_rst_hit", {31'd0, pipe_hit}, 32'd1);
        check("post_rst_stall", {31'd0, stall}, 32'd0);
        check("post_rst_terr", {31'd0, timeout_err}, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("post_rst_miss_count", miss_count, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
